image_loader: RTL and testbench
===============================

IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 12: pixel width, packed {B[11:8],G[7:4],R[3:0]}.
REQ-002 Parameter ADDR_WIDTH, default 19: BRAM address width.
REQ-003 Parameter DATA_LENGTH, default 120000: pixels per frame (400 x 300).
REQ-004 Parameter IMG_WIDTH, default 400: pixels per row.
REQ-005 Port clk_p  input  1: single clock, all logic on rising edge.
REQ-006 Port rst  input  1: reset, asynchronous, active-high.
REQ-007 Port start  input  1: one-cycle pulse arming a frame load.
REQ-008 Port s_valid  input  1: upstream pixel valid.
REQ-009 Port s_ready  output  1: loader accepts pixel.
REQ-010 Port s_data  input  DATA_WIDTH: upstream pixel.
REQ-011 Port s_last  input  1: marks final pixel of frame, sampled with s_valid.
REQ-012 Port bram_we  output  1: BRAM write enable.
REQ-013 Port bram_addr  output  ADDR_WIDTH: BRAM write address.
REQ-014 Port bram_data  output  DATA_WIDTH: BRAM write data.
REQ-015 Port row  output  9: row of the most recent accepted pixel.
REQ-016 Port col  output  10: column of the most recent accepted pixel.
REQ-017 Port frame_done  output  1: level, frame loaded correctly.
REQ-018 Port frame_err  output  1: level, s_last position wrong.

Function
REQ-019 FSM states IDLE, LOAD, DONE, ERR; reset state IDLE.
REQ-020 IDLE: s_ready=0; start -> LOAD, pixel counter, row, col cleared to 0.
REQ-021 LOAD: s_ready=1; handshake = s_valid && s_ready.
REQ-022 Handshake -> next cycle bram_we=1, bram_addr=pixel counter value at acceptance, bram_data=pixel (1-cycle latency); bram_we=0 otherwise.
REQ-023 Each handshake: pixel counter +1; col +1, wraps IMG_WIDTH-1 -> 0 with row +1.
REQ-024 Handshake with counter==DATA_LENGTH-1 and s_last=1 -> DONE.
REQ-025 Handshake with s_last=1 and counter<DATA_LENGTH-1 (early) -> ERR.
REQ-026 Handshake with counter==DATA_LENGTH-1 and s_last=0 (missing) -> ERR.
REQ-027 The pixel accepted on the terminating handshake (REQ-024..026) SHALL still be written.
REQ-028 DONE: s_ready=0, frame_done=1; start -> LOAD, clears frame_done and counters.
REQ-029 ERR: s_ready=0, frame_err=1; start -> LOAD, clears frame_err and counters.
REQ-030 start in LOAD SHALL be ignored; s_valid outside LOAD SHALL be ignored (no write).
REQ-031 frame_done and frame_err SHALL never be 1 simultaneously.
REQ-032 Address arithmetic unsigned, ADDR_WIDTH bits; counter never exceeds DATA_LENGTH-1.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, s_ready=0, bram_we=0, bram_addr=0, bram_data=0, row=0, col=0, frame_done=0, frame_err=0, counter=0.
REQ-034 Reset mid-LOAD SHALL abort the frame; no write is issued after rst asserts; a new start is required.

Configuration
REQ-035 Macro LOADER_GRAY_EN defined: bram_data = {g,g,g}, g = (R>>2)+(G>>1)+(B>>3), 4-bit, no overflow (max 11).
REQ-036 Macro LOADER_GRAY_EN undefined: bram_data = s_data unchanged; latency identical in both builds.

Verification
REQ-037 start, 120000 pixels s_valid=1 continuous, s_last on last -> last write addr 119999, row=299, col=399, frame_done=1, frame_err=0.
REQ-038 Same frame with s_valid toggling 1/0 every cycle -> 120000 writes, addresses contiguous 0..119999, frame_done=1.
REQ-039 s_last on pixel index 500 -> write at addr 500 occurs, then frame_err=1, s_ready=0, no further writes.
REQ-040 120000 pixels, s_last never set -> frame_err=1 after addr 119999 write; start -> LOAD, frame_err=0, next write addr 0.
REQ-041 LOADER_GRAY_EN build, s_data=12'hFFF -> bram_data=12'hBBB; default build -> 12'hFFF.
REQ-042 rst pulse at pixel 1000 -> outputs at reset values same cycle, no writes until start; subsequent frame writes from addr 0.

Source files
------------

// File: rtl/image_loader.sv
//------------------------------------------------------------------------------
// Module   : image_loader
// Purpose  : Streams one frame of pixels into BRAM and checks that s_last lines
//            up with the final pixel. Optional macro LOADER_GRAY_EN writes
//            grayscale {g,g,g} instead of the raw pixel.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module image_loader #(
  parameter int DATA_WIDTH  = 12,
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_LENGTH = 120000,
  parameter int IMG_WIDTH   = 400
) (
  input  logic                  clk_p,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_data,
  output logic [8:0]            row,
  output logic [9:0]            col,
  output logic                  frame_done,
  output logic                  frame_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(DATA_LENGTH - 1);
  localparam logic [9:0]            C_LAST_COL  = 10'(IMG_WIDTH - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [8:0]            r_next_row;
  logic [9:0]            r_next_col;

  logic                  w_hs;
  logic                  w_at_end;
  logic [DATA_WIDTH-1:0] w_pix;

  assign w_hs     = s_valid && s_ready;
  assign w_at_end = (r_cnt == C_LAST_ADDR);

`ifdef LOADER_GRAY_EN
  // Weights 1/4, 1/2, 1/8 on 4-bit channels keep the sum at or below 11.
  logic [3:0] w_gray;
  logic       w_unused_bits;
  assign w_gray        = {2'b00, s_data[3:2]} + {1'b0, s_data[7:5]} + {3'b000, s_data[11]};
  assign w_pix         = DATA_WIDTH'({w_gray, w_gray, w_gray});
  assign w_unused_bits = ^{s_data[1:0], s_data[4], s_data[10:8]};
`else
  assign w_pix = s_data;
`endif

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_next_row <= '0;
      r_next_col <= '0;
      s_ready    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_data  <= '0;
      row        <= '0;
      col        <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      bram_we <= 1'b0;
      case (r_state)
        LOAD: begin
          if (w_hs) begin
            bram_we   <= 1'b1;
            bram_addr <= r_cnt;
            bram_data <= w_pix;
            row       <= r_next_row;
            col       <= r_next_col;
            if (r_next_col == C_LAST_COL) begin
              r_next_col <= '0;
              r_next_row <= r_next_row + 9'd1;
            end else begin
              r_next_col <= r_next_col + 10'd1;
            end
            // The terminating pixel is still written; the counter stops here.
            if (w_at_end || s_last) begin
              s_ready <= 1'b0;
              if (w_at_end && s_last) begin
                r_state    <= DONE;
                frame_done <= 1'b1;
              end else begin
                r_state   <= ERR;
                frame_err <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          if (start) begin
            r_state    <= LOAD;
            s_ready    <= 1'b1;
            r_cnt      <= '0;
            r_next_row <= '0;
            r_next_col <= '0;
            row        <= '0;
            col        <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_image_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_image_loader
// Purpose  : Directed bench for image_loader on a reduced 8 x 3 frame.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_image_loader;

  localparam int DW = 12;
  localparam int AW = 19;
  localparam int L  = 24;
  localparam int W  = 8;

  logic          clk_p = 1'b0;
  logic          rst;
  logic          start;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_data;
  logic [8:0]    row;
  logic [9:0]    col;
  logic          frame_done;
  logic          frame_err;

  int n_vec = 0;
  int n_err = 0;

  image_loader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DATA_LENGTH(L),
    .IMG_WIDTH  (W)
  ) dut (
    .clk_p     (clk_p),
    .rst       (rst),
    .start     (start),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_data (bram_data),
    .row       (row),
    .col       (col),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  always #5 clk_p = ~clk_p;

  function automatic logic [11:0] pix(input int k);
    if (k == 3) return 12'hFFF;
    return 12'((k * 37 + 5) ^ 12'h5A3);
  endfunction

  function automatic logic [11:0] expect_data(input logic [11:0] p);
`ifdef LOADER_GRAY_EN
    logic [3:0] g;
    g = (p[3:0] >> 2) + (p[7:4] >> 1) + (p[11:8] >> 3);
    return {g, g, g};
`else
    return p;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_p);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ready", 32'(s_ready), 32'd1);
    chk("start_row", 32'(row), 32'd0);
    chk("start_col", 32'(col), 32'd0);
    chk("start_done", 32'(frame_done), 32'd0);
    chk("start_err", 32'(frame_err), 32'd0);
  endtask

  task automatic send(input int k, input bit last, input bit strt);
    s_valid = 1'b1;
    s_data  = pix(k);
    s_last  = last;
    start   = strt;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    start   = 1'b0;
    chk("wr_we", 32'(bram_we), 32'd1);
    chk("wr_addr", 32'(bram_addr), 32'(k));
    chk("wr_data", 32'(bram_data), 32'(expect_data(pix(k))));
    chk("wr_row", 32'(row), 32'(k / W));
    chk("wr_col", 32'(col), 32'(k % W));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_we"}, 32'(bram_we), 32'd0);
    chk({tag, "_addr"}, 32'(bram_addr), 32'd0);
    chk({tag, "_data"}, 32'(bram_data), 32'd0);
    chk({tag, "_row"}, 32'(row), 32'd0);
    chk({tag, "_col"}, 32'(col), 32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    step();
    step();
    chk_reset_outputs("rst");
    rst = 1'b0;
    step();

    // Pixels offered while idle are ignored
    s_valid = 1'b1;
    s_data  = 12'h123;
    step();
    s_valid = 1'b0;
    chk("idle_we", 32'(bram_we), 32'd0);
    chk("idle_ready", 32'(s_ready), 32'd0);

    // Continuous frame with a stray start mid-load
    go();
    for (int k = 0; k < L; k++) send(k, k == L - 1, k == 5);
    chk("a_done", 32'(frame_done), 32'd1);
    chk("a_err", 32'(frame_err), 32'd0);
    chk("a_ready", 32'(s_ready), 32'd0);
    chk("a_row", 32'(row), 32'd2);
    chk("a_col", 32'(col), 32'd7);
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    chk("done_ignore_we", 32'(bram_we), 32'd0);
    chk("done_hold", 32'(frame_done), 32'd1);

    // Valid toggling every cycle
    go();
    for (int k = 0; k < L; k++) begin
      send(k, k == L - 1, 1'b0);
      if (k != L - 1) begin
        step();
        chk("b_gap_we", 32'(bram_we), 32'd0);
      end
    end
    chk("b_done", 32'(frame_done), 32'd1);
    chk("b_err", 32'(frame_err), 32'd0);

    // Early s_last
    go();
    for (int k = 0; k <= 10; k++) send(k, k == 10, 1'b0);
    chk("c_err", 32'(frame_err), 32'd1);
    chk("c_done", 32'(frame_done), 32'd0);
    chk("c_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    chk("c_no_write", 32'(bram_we), 32'd0);
    chk("c_row", 32'(row), 32'd1);
    chk("c_col", 32'(col), 32'd2);

    // Missing s_last
    go();
    for (int k = 0; k < L; k++) send(k, 1'b0, 1'b0);
    chk("d_err", 32'(frame_err), 32'd1);
    chk("d_done", 32'(frame_done), 32'd0);
    chk("d_ready", 32'(s_ready), 32'd0);

    // Restart after error, then abort by reset mid-frame
    go();
    for (int k = 0; k < 5; k++) send(k, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    s_valid = 1'b1;
    step();
    chk("rst_hold_we", 32'(bram_we), 32'd0);
    rst = 1'b0;
    step();
    s_valid = 1'b0;
    chk("post_rst_we", 32'(bram_we), 32'd0);
    chk("post_rst_ready", 32'(s_ready), 32'd0);

    go();
    for (int k = 0; k < L; k++) send(k, k == L - 1, 1'b0);
    chk("e_done", 32'(frame_done), 32'd1);
    chk("e_err", 32'(frame_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
